// File: rtl/amp_pkg.sv
// Shared types and default sizing for the duty ramp controller.
package amp_pkg;

  localparam int DEF_N    = 4;
  localparam int DEF_STEP = 1;

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    RAMP_DOWN
  } state_t;

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer followed by a rising-edge detector for one raw button.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic sync1;
  logic sync2;
  logic prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign press = sync2 & ~prev;

endmodule

// File: rtl/duty_ramp_ctrl.sv
// Button-driven PWM duty target with a one-LSB-per-period ramp toward it.
// Optional mute feature compiled in with `define DUTY_RAMP_MUTE_EN.
module duty_ramp_ctrl
  import amp_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int STEP = DEF_STEP
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [1:0]   buttons,
  input  logic         pwm_step,
  output logic [N-1:0] duty,
  output logic         duty_load,
  output logic [1:0]   leds,
  output logic         busy
);

  localparam logic [N:0]   STEP_W = (N+1)'(STEP);
  localparam logic [N:0]   MAX_W  = {1'b0, {N{1'b1}}};
  localparam logic [N-1:0] MAX_N  = {N{1'b1}};

  logic         up_press;
  logic         dn_press;
  logic [N-1:0] target;
  logic [N-1:0] target_next;
  logic [N-1:0] duty_next;
  logic [N-1:0] eff_next;
  logic [N:0]   up_sum;
  logic         load_next;
  state_t       state;
  state_t       state_next;

  btn_edge u_btn_up (
    .clk   (clk),
    .rst   (rst),
    .btn   (buttons[0]),
    .press (up_press)
  );

  btn_edge u_btn_dn (
    .clk   (clk),
    .rst   (rst),
    .btn   (buttons[1]),
    .press (dn_press)
  );

`ifdef DUTY_RAMP_MUTE_EN
  logic muted;
  logic muted_next;
`endif

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    target_next = target;
    duty_next   = duty;
    load_next   = 1'b0;
    up_sum      = {1'b0, target} + STEP_W;
`ifdef DUTY_RAMP_MUTE_EN
    muted_next  = muted;
    if (ena) begin
      if (up_press && dn_press) begin
        muted_next = ~muted;
      end else if (!muted && up_press) begin
        target_next = (up_sum > MAX_W) ? MAX_N : up_sum[N-1:0];
      end else if (!muted && dn_press) begin
        target_next = ({1'b0, target} < STEP_W) ? '0 : target - STEP_W[N-1:0];
      end
    end
    eff_next = muted_next ? '0 : target_next;
`else
    if (ena) begin
      if (up_press && !dn_press) begin
        target_next = (up_sum > MAX_W) ? MAX_N : up_sum[N-1:0];
      end else if (dn_press && !up_press) begin
        target_next = ({1'b0, target} < STEP_W) ? '0 : target - STEP_W[N-1:0];
      end
    end
    eff_next = target_next;
`endif

    // Duty moves only on a period boundary, in the direction the current state holds.
    if (ena && pwm_step) begin
      unique case (state)
        RAMP_UP: begin
          duty_next = duty + 1'b1;
          load_next = 1'b1;
        end
        RAMP_DOWN: begin
          duty_next = duty - 1'b1;
          load_next = 1'b1;
        end
        default: ;
      endcase
    end

    if (duty_next < eff_next) begin
      state_next = RAMP_UP;
    end else if (duty_next > eff_next) begin
      state_next = RAMP_DOWN;
    end else begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target    <= '0;
      duty      <= '0;
      duty_load <= 1'b0;
      state     <= IDLE;
`ifdef DUTY_RAMP_MUTE_EN
      muted     <= 1'b0;
`endif
    end else begin
      target    <= target_next;
      duty      <= duty_next;
      duty_load <= load_next;
      state     <= state_next;
`ifdef DUTY_RAMP_MUTE_EN
      muted     <= muted_next;
`endif
    end
  end

  assign busy = (state != IDLE);

`ifdef DUTY_RAMP_MUTE_EN
  assign leds = muted ? 2'b11 : {target == '0, target == MAX_N};
`else
  assign leds = {target == '0, target == MAX_N};
`endif

endmodule

// File: tb/tb_duty_ramp_ctrl.sv
// Scoreboard bench for duty_ramp_ctrl: expected duty values are queued per ramp and
// popped by a monitor on every duty_load strobe.
module tb_duty_ramp_ctrl;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [1:0] buttons;
  logic       pwm_step;
  logic [3:0] duty;
  logic       duty_load;
  logic [1:0] leds;
  logic       busy;

  int n_cmp;
  int n_err;
  logic [3:0] exp_q[$];

  duty_ramp_ctrl #(.N(4), .STEP(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .buttons   (buttons),
    .pwm_step  (pwm_step),
    .duty      (duty),
    .duty_load (duty_load),
    .leds      (leds),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every duty_load must match the oldest queued expectation.
  always @(negedge clk) begin
    if (duty_load) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_load: duty=%0d with nothing queued at %0t", duty, $time);
      end else begin
        check("duty_on_load", 32'(duty), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic press(input logic [1:0] m, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      buttons = m;
      repeat (4) @(negedge clk);
      buttons = 2'b00;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic step_pwm(input int n);
    for (int k = 0; k < n; k++) begin
      repeat (119) @(negedge clk);
      pwm_step = 1'b1;
      @(negedge clk);
      pwm_step = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic expect_ramp(input int from, input int to);
    if (to > from) begin
      for (int v = from + 1; v <= to; v++) exp_q.push_back(4'(v));
    end else begin
      for (int v = from - 1; v >= to; v--) exp_q.push_back(4'(v));
    end
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 50; i++) begin
      if (busy == 1'b0) break;
      @(negedge clk);
    end
    check(nm, 32'(busy), 32'd0);
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    ena      = 1'b1;
    buttons  = 2'b00;
    pwm_step = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_duty", 32'(duty), 32'd0);
    check("rst_load", 32'(duty_load), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_leds", 32'(leds), 32'd2);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Three up presses, ramp 0->3.
    press(2'b01, 3);
    check("t3_leds", 32'(leds), 32'd0);
    check("t3_busy", 32'(busy), 32'd1);
    expect_ramp(0, 3);
    step_pwm(3);
    wait_idle("t3_idle");
    check("t3_duty", 32'(duty), 32'd3);

    // Saturation at both ends.
    press(2'b01, 12);
    check("max_leds", 32'(leds), 32'd1);
    press(2'b01, 1);
    check("max_hold_leds", 32'(leds), 32'd1);
    press(2'b10, 15);
    check("zero_leds", 32'(leds), 32'd2);
    press(2'b10, 1);
    check("zero_hold_leds", 32'(leds), 32'd2);
    check("zero_busy", 32'(busy), 32'd1);
    expect_ramp(3, 0);
    step_pwm(3);
    wait_idle("zero_idle");

    // Retarget downward mid-ramp.
    press(2'b01, 8);
    expect_ramp(0, 4);
    step_pwm(4);
    press(2'b10, 6);
    check("rev_busy", 32'(busy), 32'd1);
    expect_ramp(4, 2);
    step_pwm(2);
    wait_idle("rev_idle");
    check("rev_duty", 32'(duty), 32'd2);

    // Disable mid-ramp: presses and periods ignored.
    press(2'b01, 6);
    expect_ramp(2, 4);
    step_pwm(2);
    ena = 1'b0;
    press(2'b01, 1);
    press(2'b10, 1);
    step_pwm(2);
    check("dis_duty", 32'(duty), 32'd4);
    check("dis_busy", 32'(busy), 32'd1);
    check("dis_leds", 32'(leds), 32'd0);
    ena = 1'b1;
    expect_ramp(4, 8);
    step_pwm(4);
    wait_idle("dis_idle");
    check("dis_final_duty", 32'(duty), 32'd8);

    // Reset mid-ramp at duty=6.
    press(2'b10, 8);
    check("pre_rst_leds", 32'(leds), 32'd2);
    expect_ramp(8, 6);
    step_pwm(2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_duty", 32'(duty), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_leds", 32'(leds), 32'd2);
    check("mid_rst_load", 32'(duty_load), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_load", 32'(duty_load), 32'd0);
    check("post_rst_duty", 32'(duty), 32'd0);

`ifdef DUTY_RAMP_MUTE_EN
    press(2'b01, 10);
    expect_ramp(0, 10);
    step_pwm(10);
    wait_idle("mute_pre_idle");
    press(2'b11, 1);
    check("mute_leds", 32'(leds), 32'd3);
    check("mute_busy", 32'(busy), 32'd1);
    expect_ramp(10, 0);
    step_pwm(10);
    wait_idle("mute_idle");
    check("mute_duty", 32'(duty), 32'd0);
    press(2'b01, 1);
    check("mute_ignore_leds", 32'(leds), 32'd3);
    check("mute_ignore_busy", 32'(busy), 32'd0);
    press(2'b11, 1);
    check("unmute_leds", 32'(leds), 32'd0);
    expect_ramp(0, 10);
    step_pwm(10);
    wait_idle("unmute_idle");
    check("unmute_duty", 32'(duty), 32'd10);
`else
    press(2'b11, 1);
    check("both_leds", 32'(leds), 32'd2);
    check("both_busy", 32'(busy), 32'd0);
    press(2'b01, 1);
    check("after_both_leds", 32'(leds), 32'd0);
    expect_ramp(0, 1);
    step_pwm(1);
    wait_idle("after_both_idle");
    check("after_both_duty", 32'(duty), 32'd1);
`endif

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/duty_ramp_ctrl.md
DUTY_RAMP_CTRL -- requirements
Module: duty_ramp_ctrl

Interface
REQ-001 SHALL have parameter N, default 4, PWM duty width in bits.
REQ-002 SHALL have parameter STEP, default 1, target change per button press (1..2^N-1).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ena  input  1  controller enable; low freezes duty and ignores presses.
REQ-006 SHALL have port buttons  input  2  raw asynchronous buttons: [0]=up, [1]=down.
REQ-007 SHALL have port pwm_step  input  1  one-cycle pulse marking the PWM period boundary.
REQ-008 SHALL have port duty  output  N  registered duty value driven to the PWM.
REQ-009 SHALL have port duty_load  output  1  one-cycle strobe, high in the cycle duty takes a new value.
REQ-010 SHALL have port leds  output  2  status: [0]=target at max, [1]=target at zero or muted.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL pass each button through a two-flop synchronizer, then a rising-edge detector, giving a one-cycle press pulse.
REQ-013 SHALL update target on the 3rd rising clk edge after a button is first sampled high; holding a button gives exactly one press.
REQ-014 SHALL, on an up press, set target = min(target+STEP, 2^N-1), computed at N+1 bits, no wrap.
REQ-015 SHALL, on a down press, set target = max(target-STEP, 0), no wrap below zero.
REQ-016 SHALL, on simultaneous up and down presses in one cycle, leave target unchanged (macro-dependent, see REQ-029).
REQ-017 SHALL implement states IDLE (duty==target), RAMP_UP (duty<target), RAMP_DOWN (duty>target).
REQ-018 SHALL select the next state from the comparison of duty with the effective target each cycle.
REQ-019 SHALL, on pwm_step with ena=1 in RAMP_UP/RAMP_DOWN, move duty one LSB toward target on the next clock edge.
REQ-020 SHALL assert duty_load for exactly the cycle in which duty shows its new value.
REQ-021 SHALL never change duty except as REQ-019; at most one LSB per pwm_step.
REQ-022 SHALL, on a target change mid-ramp, retarget immediately; direction reverses on the next pwm_step if needed.
REQ-023 SHALL, while ena=0, ignore presses, hold duty and target, keep duty_load=0 and keep the state unchanged.
REQ-024 SHALL discard a press whose pulse occurs while ena=0; no queued action after ena rises.
REQ-025 SHALL drive leds combinationally from registered target and mute state only.

Reset
REQ-026 SHALL, with rst=1 at a clock edge, set duty=0, target=0, state=IDLE, duty_load=0, busy=0, leds=2'b10, synchronizers cleared.
REQ-027 SHALL, on reset mid-ramp, abandon the ramp with no duty_load pulse in the reset cycle or the cycle after.

Configuration
REQ-028 SHALL use macro DUTY_RAMP_MUTE_EN to compile a mute feature in or out.
REQ-029 SHALL, with DUTY_RAMP_MUTE_EN defined, toggle mute on simultaneous up+down presses; muted, the effective target is 0, leds=2'b11 and single presses are ignored; unmute ramps back to the retained target.
REQ-030 SHALL, without DUTY_RAMP_MUTE_EN, contain no mute logic; simultaneous presses are no-ops.

Structure
REQ-031 SHALL place the state enum (IDLE, RAMP_UP, RAMP_DOWN) and default N/STEP constants in shared package amp_pkg.
REQ-032 SHALL instantiate sub-module btn_edge (synchronizer plus rising-edge detector), one per button.

Verification
REQ-033 SHALL cover: reset, then 3 up presses with STEP=1 and pwm_step every 120 clocks -> target=3; duty 0->1->2->3 on consecutive pwm_steps, duty_load pulsing each time; then busy=0.
REQ-034 SHALL cover: target=15, up press -> target stays 15, leds[0]=1; from target=0, down press -> target stays 0, leds[1]=1.
REQ-035 SHALL cover: duty ramping up to 8 at duty=4, down press x6 (target=2) -> duty goes 5? no: next pwm_step gives duty=3, then 2, state RAMP_DOWN then IDLE.
REQ-036 SHALL cover: ena=0 during ramp with presses and pwm_steps -> duty, target unchanged and duty_load=0; ena=1 -> ramp resumes with no stale press applied.
REQ-037 SHALL cover: rst asserted mid-ramp at duty=6 -> next cycle duty=0, target=0, busy=0, leds=2'b10.
REQ-038 SHALL cover (DUTY_RAMP_MUTE_EN): target=10, both buttons pressed together -> leds=2'b11, duty ramps to 0; pressing both again -> duty ramps back to 10.
